// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the synchronous FIFO controller and its storage.
package sync_fifo_pkg;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 7;
  localparam int DEF_AFULL_TH  = 120;
  localparam int DEF_AEMPTY_TH = 8;

  // Pointers carry one extra wrap bit; count spans 0..depth inclusive.
  typedef logic [DEF_ADDR_W:0] ptr_t;
  typedef logic [DEF_ADDR_W:0] count_t;
endpackage

// File: rtl/fifo_storage.sv
// Simple dual-port array with a registered read port; the array itself is never reset.
module fifo_storage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Only the output register is reset so the pop data port starts at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i)        rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, registered flags around fifo_storage.
// Optional sticky overflow/underflow flags are enabled with SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AFULL_TH  = DEF_AFULL_TH,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              pop_valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o,
  output logic              underflow_o
);
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_TH = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_TH = AEMPTY_TH[ADDR_W:0];

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic            full_q, empty_q, afull_q, aempty_q, pop_valid_q;
  logic            push_ok, pop_ok;

  // Acceptance looks only at registered flags, so a full FIFO never takes a push
  // even when a pop frees a slot in the same cycle (and likewise no empty bypass).
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i  && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      pop_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= (count_d == DEPTH);
      empty_q     <= (count_d == '0);
      afull_q     <= (count_d >= AF_TH);
      aempty_q    <= (count_d <= AE_TH);
      pop_valid_q <= pop_ok;
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_i && full_q) overflow_q  <= 1'b1;
      if (pop_i && empty_q) underflow_q <= 1'b1;
    end
  end
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

  fifo_storage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_storage (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (push_ok && !rst_i),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i (push_data_i),
    .rd_en_i   (pop_ok && !rst_i),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (pop_data_o)
  );

  assign count_o        = count_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign pop_valid_o    = pop_valid_q;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed self-checking bench for sync_fifo_ctrl (default 128 x 8 geometry).
module tb_sync_fifo_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_i, push_i, pop_i;
  logic [7:0] push_data_i, pop_data_o;
  logic       pop_valid_o, full_o, empty_o, almost_full_o, almost_empty_o;
  logic [7:0] count_o;
  logic       overflow_o, underflow_o;
  int         n_cmp = 0, n_err = 0;
  logic       exp_err;

  sync_fifo_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(push_i), .push_data_i(push_data_i),
    .pop_i(pop_i), .pop_data_o(pop_data_o), .pop_valid_o(pop_valid_o),
    .full_o(full_o), .empty_o(empty_o), .almost_full_o(almost_full_o),
    .almost_empty_o(almost_empty_o), .count_o(count_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    push_i = 1'b0; pop_i = 1'b0; push_data_i = 8'h00;
  endtask

  task automatic test_reset();
    idle(); rst_i = 1'b1; tick(); tick(); rst_i = 1'b0; tick();
    n_cmp++;
    if ({empty_o, almost_empty_o, full_o, almost_full_o, pop_valid_o, count_o, pop_data_o, overflow_o, underflow_o}
        !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: emp=%b aemp=%b full=%b afull=%b pv=%b cnt=%0d pd=%h ovf=%b udf=%b, required 1 1 0 0 0 0 00 0 0",
               empty_o, almost_empty_o, full_o, almost_full_o, pop_valid_o, count_o, pop_data_o, overflow_o, underflow_o);
    end
  endtask

  task automatic fill(input int base);
    logic [7:0] c;
    for (int i = 0; i < 128; i++) begin
      push_i = 1'b1; push_data_i = 8'(base + i); tick();
      c = 8'(i + 1);
      n_cmp++;
      if ({count_o, full_o, almost_full_o, empty_o, almost_empty_o}
          !== {c, (i == 127), (i >= 119), 1'b0, (i < 8)}) begin
        n_err++;
        $display("FAIL fill_flags i=%0d: cnt=%0d full=%b afull=%b emp=%b aemp=%b, required cnt=%0d full=%b afull=%b emp=0 aemp=%b",
                 i, count_o, full_o, almost_full_o, empty_o, almost_empty_o, c, (i == 127), (i >= 119), (i < 8));
      end
    end
    idle();
  endtask

  task automatic test_fill_drain();
    fill(0);
    for (int i = 0; i < 128; i++) begin
      pop_i = 1'b1; tick();
      n_cmp++;
      if ({pop_valid_o, pop_data_o, count_o} !== {1'b1, 8'(i), 8'(127 - i)}) begin
        n_err++;
        $display("FAIL drain_data i=%0d: pv=%b pd=%h cnt=%0d, required pv=1 pd=%h cnt=%0d",
                 i, pop_valid_o, pop_data_o, count_o, 8'(i), 127 - i);
      end
    end
    idle(); tick();
    n_cmp++;
    if ({empty_o, pop_valid_o, full_o} !== 3'b100) begin
      n_err++;
      $display("FAIL drain_empty: emp=%b pv=%b full=%b, required 1 0 0", empty_o, pop_valid_o, full_o);
    end
  endtask

  task automatic test_empty_push_pop();
    push_i = 1'b1; pop_i = 1'b1; push_data_i = 8'hA5; tick(); idle();
    n_cmp++;
    if ({count_o, pop_valid_o, empty_o, pop_data_o} !== {8'd1, 1'b0, 1'b0, 8'h7F}) begin
      n_err++;
      $display("FAIL empty_pushpop: cnt=%0d pv=%b emp=%b pd=%h, required cnt=1 pv=0 emp=0 pd=7f",
               count_o, pop_valid_o, empty_o, pop_data_o);
    end
    pop_i = 1'b1; tick(); idle();
    n_cmp++;
    if ({pop_valid_o, pop_data_o, count_o, empty_o} !== {1'b1, 8'hA5, 8'd0, 1'b1}) begin
      n_err++;
      $display("FAIL empty_then_pop: pv=%b pd=%h cnt=%0d emp=%b, required pv=1 pd=a5 cnt=0 emp=1",
               pop_valid_o, pop_data_o, count_o, empty_o);
    end
    tick();
    n_cmp++;
    if (pop_valid_o !== 1'b0) begin
      n_err++; $display("FAIL pop_valid_pulse: pv=%b, required 0", pop_valid_o);
    end
  endtask

  task automatic test_full_push_pop();
    fill(8'h40);
    push_i = 1'b1; pop_i = 1'b1; push_data_i = 8'h11; tick(); idle();
    n_cmp++;
    if ({pop_valid_o, pop_data_o, count_o, full_o, overflow_o} !== {1'b1, 8'h40, 8'd127, 1'b0, exp_err}) begin
      n_err++;
      $display("FAIL full_pushpop: pv=%b pd=%h cnt=%0d full=%b ovf=%b, required pv=1 pd=40 cnt=127 full=0 ovf=%b",
               pop_valid_o, pop_data_o, count_o, full_o, overflow_o, exp_err);
    end
    tick();
    n_cmp++;
    if (overflow_o !== exp_err) begin
      n_err++; $display("FAIL overflow_sticky: ovf=%b, required %b", overflow_o, exp_err);
    end
    // Remaining words must be 0x41..0xBF; the dropped 0x11 must not appear.
    for (int i = 1; i < 128; i++) begin
      pop_i = 1'b1; tick();
      n_cmp++;
      if ({pop_valid_o, pop_data_o} !== {1'b1, 8'(8'h40 + i)}) begin
        n_err++;
        $display("FAIL full_drain i=%0d: pv=%b pd=%h, required pv=1 pd=%h", i, pop_valid_o, pop_data_o, 8'(8'h40 + i));
      end
    end
    idle(); tick();
    n_cmp++;
    if ({count_o, empty_o} !== {8'd0, 1'b1}) begin
      n_err++; $display("FAIL full_drain_end: cnt=%0d emp=%b, required cnt=0 emp=1", count_o, empty_o);
    end
  endtask

  task automatic test_underflow();
    pop_i = 1'b1; tick(); idle();
    n_cmp++;
    if ({pop_valid_o, pop_data_o, count_o, empty_o, underflow_o} !== {1'b0, 8'hBF, 8'd0, 1'b1, exp_err}) begin
      n_err++;
      $display("FAIL underflow: pv=%b pd=%h cnt=%0d emp=%b udf=%b, required pv=0 pd=bf cnt=0 emp=1 udf=%b",
               pop_valid_o, pop_data_o, count_o, empty_o, underflow_o, exp_err);
    end
    tick();
    n_cmp++;
    if (underflow_o !== exp_err) begin
      n_err++; $display("FAIL underflow_sticky: udf=%b, required %b", underflow_o, exp_err);
    end
  endtask

  task automatic test_back_to_back();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_i = 1'b1; push_data_i = 8'(i); tick();
    end
    idle();
    for (int c = 0; c < 200; c++) begin
      push_i = 1'b1; pop_i = 1'b1; push_data_i = 8'(c + 5); tick();
      n_cmp++;
      if ({count_o, pop_valid_o, pop_data_o} !== {8'd5, 1'b1, 8'(c)}) begin
        n_err++;
        $display("FAIL stream c=%0d: cnt=%0d pv=%b pd=%h, required cnt=5 pv=1 pd=%h",
                 c, count_o, pop_valid_o, pop_data_o, 8'(c));
      end
    end
    // Reset with requests still asserted: they must be ignored.
    rst_i = 1'b1; tick(); rst_i = 1'b0; idle();
    n_cmp++;
    if ({count_o, empty_o, almost_empty_o, full_o, pop_valid_o, pop_data_o, overflow_o, underflow_o}
        !== {8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL mid_reset: cnt=%0d emp=%b aemp=%b full=%b pv=%b pd=%h ovf=%b udf=%b, required 0 1 1 0 0 00 0 0",
               count_o, empty_o, almost_empty_o, full_o, pop_valid_o, pop_data_o, overflow_o, underflow_o);
    end
    tick();
    n_cmp++;
    if ({count_o, empty_o} !== {8'd0, 1'b1}) begin
      n_err++; $display("FAIL post_reset_idle: cnt=%0d emp=%b, required cnt=0 emp=1", count_o, empty_o);
    end
  endtask

  initial begin
    rst_i = 1'b1; idle();
    test_reset();
    test_fill_drain();
    test_empty_push_pop();
    test_full_push_pop();
    test_underflow();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Synchronous single-clock FIFO that drives the write and read ports of a simple dual-port, registered-read storage array. Wraps the array with write/read pointers, occupancy count and status flags, presenting a push/pop interface to producer and consumer logic. Default geometry is 128 × 8 bits.

## Interface
- DATA_W, 8, word width
- ADDR_W, 7, address width; depth = 2**ADDR_W
- AFULL_TH, 120, almost_full_o asserts when count ≥ AFULL_TH
- AEMPTY_TH, 8, almost_empty_o asserts when count ≤ AEMPTY_TH

- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- push_i  in  1  write request
- push_data_i  in  DATA_W  write data
- pop_i  in  1  read request
- pop_data_o  out  DATA_W  read data, registered
- pop_valid_o  out  1  pop_data_o carries a newly popped word this cycle
- full_o  out  1  count == depth
- empty_o  out  1  count == 0
- almost_full_o  out  1  count ≥ AFULL_TH
- almost_empty_o  out  1  count ≤ AEMPTY_TH
- count_o  out  ADDR_W+1  occupancy, 0..depth
- overflow_o  out  1  sticky, push while full (see Configuration)
- underflow_o  out  1  sticky, pop while empty (see Configuration)

## Operation
- Pointers wr_ptr, rd_ptr: ADDR_W+1 bits; low ADDR_W bits address storage, MSB is the wrap bit; both wrap naturally from depth−1 to 0.
- Push accepted iff push_i && !full_o (registered flag). Accepted: storage write at wr_ptr, wr_ptr+1.
- Pop accepted iff pop_i && !empty_o (registered flag). Accepted: storage read at rd_ptr, rd_ptr+1.
- Rejected requests have no effect on pointers, count or storage.
- Simultaneous push+pop, neither full nor empty: both accepted, count unchanged.
- Simultaneous push+pop while full: pop accepted, push rejected; count → depth−1.
- Simultaneous push+pop while empty: push accepted, pop rejected (no bypass); count → 1.
- count_o: +1 on push-only, −1 on pop-only, unchanged otherwise. Never exceeds depth or goes below 0.
- All flags registered, computed from next-state count.
- pop_data_o holds its last value when no pop is accepted; pop_valid_o is a single-cycle pulse per accepted pop.
- Storage contents are not cleared by reset; only locations written since reset are ever read.
- Reset values: pointers 0, count_o 0, empty_o 1, almost_empty_o 1, full_o 0, almost_full_o 0, pop_valid_o 0, pop_data_o 0, overflow_o 0, underflow_o 0.
- Reset mid-operation discards all contents; requests in the reset cycle are ignored; FIFO is empty in the following cycle.

## Timing
- Push at edge N: count_o/flags reflect it after edge N; word is poppable by a pop in cycle N+1.
- Pop at edge N: pop_data_o and pop_valid_o valid after edge N (1-cycle read latency).
- Back-to-back pops at full rate deliver one word per cycle in FIFO order.
- Minimum push-to-pop_data_o latency through an empty FIFO: 2 cycles.
- Full throughput: one push and one pop per cycle sustained when neither full nor empty.

## Configuration
- SYNC_FIFO_ERR_FLAGS_EN defined: overflow_o sets on push_i while full_o; underflow_o sets on pop_i while empty_o; both sticky until rst_i.
- Not defined: no error-flag registers; overflow_o and underflow_o tied to 0. Ports present in both builds.

## Structure
- Shared package sync_fifo_pkg: default DATA_W/ADDR_W constants, ptr_t/count_t typedefs derived from ADDR_W.
- One sub-module: fifo_storage — 2**ADDR_W × DATA_W simple dual-port array, write port (en/addr/data) and registered read port (en/addr/data), no reset on the array. Controller owns pointers, count, flags.

## Test plan
- Reset, then idle → empty_o=1, almost_empty_o=1, count_o=0, full_o=0, pop_valid_o=0, pop_data_o=0x00.
- Push 0x00..0x7F (128 words), pop all → full_o=1 after 128th push, almost_full_o from count 120; pops return 0x00..0x7F in order, one per cycle, empty_o=1 after last.
- Push 0xA5 into empty FIFO with simultaneous pop → push accepted, pop ignored, count_o=1, pop_valid_o stays 0; pop next cycle → 0xA5 with pop_valid_o one cycle later.
- Fill to 128, then push 0x11 + pop together → pop returns first word, 0x11 dropped, count_o=127; with macro, push while full sets overflow_o=1 and it stays set.
- Pop on empty → no state change, pop_data_o unchanged; with macro underflow_o=1, without macro 0.
- 200 cycles of continuous push+pop after pre-filling 5 words → count_o constant 5, data order preserved across pointer wrap; assert rst_i mid-stream → next cycle count_o=0, empty_o=1, flags cleared.
